// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state enum,
// ALU op / mux select codes, pc_src codes, opcode and funct constants.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_R,
      S_WB_I,
      S_WB_MEM,
      S_BRANCH,
      S_JUMP,
      S_HALT
   } state_e;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_PASS = 3'b101;

   localparam logic [1:0] A1_PC   = 2'b00;
   localparam logic [1:0] A1_A    = 2'b01;
   localparam logic [1:0] A1_ZERO = 2'b10;
   localparam logic [1:0] A1_AUX  = 2'b11;

   localparam logic [1:0] A2_B     = 2'b00;
   localparam logic [1:0] A2_FOUR  = 2'b01;
   localparam logic [1:0] A2_IMM   = 2'b10;
   localparam logic [1:0] A2_IMMS2 = 2'b11;

   localparam logic [1:0] PC_ALU  = 2'b00;
   localparam logic [1:0] PC_AOUT = 2'b01;
   localparam logic [1:0] PC_JUMP = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct decoder: funct -> {alu_op, valid}. Purely combinational.
// Ports: funct (in 6), alu_op (out 3), valid (out 1).
module alu_op_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       valid
);

   always_comb begin
      alu_op = ALU_ADD;
      valid  = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_SLT:  alu_op = ALU_SLT;
         default: valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_alu_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with a
// mem_req/mem_ready handshake and memory timeout leading to a sticky HALT.
// Ports: clk, reset (sync, high); opcode, funct, zero_flag, mem_ready in;
// ALU1control, ALU2control, ALUop, pc_write, pc_src, ir_write, mem_req,
// mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal_op, halted out.
// Option: define CTRL_LUI_EN to decode opcode 0x0F as lui (aux pass).
module mc_alu_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero_flag,
   input  logic       mem_ready,
   output logic [1:0] ALU1control,
   output logic [1:0] ALU2control,
   output logic [2:0] ALUop,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal_op,
   output logic       halted
);

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] fn_op;
   logic       fn_ok;
   logic       wait_to;

   alu_op_decode u_dec (
      .funct  (funct),
      .alu_op (fn_op),
      .valid  (fn_ok)
   );

   // Last permitted waiting cycle of a memory state.
   assign wait_to = (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = 8'd0;
      ALU1control = A1_PC;
      ALU2control = A2_B;
      ALUop       = ALU_ADD;
      pc_write    = 1'b0;
      pc_src      = PC_ALU;
      ir_write    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal_op  = 1'b0;
      halted      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write    = 1'b1;
               ALU2control = A2_FOUR;
               pc_write    = 1'b1;
               state_d     = S_DECODE;
            end else if (wait_to) begin
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            ALU2control = A2_IMMS2;
            case (opcode)
               OP_RTYPE: begin
                  if (fn_ok) begin
                     state_d = S_EXEC_R;
                  end else begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               OP_ADDI: state_d = S_EXEC_I;
`ifdef CTRL_LUI_EN
               OP_LUI:  state_d = S_EXEC_I;
`endif
               OP_LW,
               OP_SW:   state_d = S_ADDR;
               OP_BEQ,
               OP_BNE:  state_d = S_BRANCH;
               OP_J:    state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            ALU1control = A1_A;
            ALUop       = fn_op;
            state_d     = S_WB_R;
         end
         S_EXEC_I: begin
            ALU1control = A1_A;
            ALU2control = A2_IMM;
`ifdef CTRL_LUI_EN
            if (opcode == OP_LUI) begin
               ALU1control = A1_AUX;
               ALUop       = ALU_PASS;
            end
`endif
            state_d = S_WB_I;
         end
         S_ADDR: begin
            ALU1control = A1_A;
            ALU2control = A2_IMM;
            state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD, S_MEM_WR: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (state_q == S_MEM_WR);
            if (mem_ready) begin
               state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
            end else if (wait_to) begin
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            ALU1control = A1_A;
            ALUop       = ALU_SUB;
            pc_src      = PC_AOUT;
            pc_write    = (opcode == OP_BNE) ? !zero_flag : zero_flag;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset masks every output in the same cycle, not just the next one.
      if (reset) begin
         ALU1control = A1_PC;
         ALU2control = A2_B;
         ALUop       = ALU_ADD;
         pc_write    = 1'b0;
         pc_src      = PC_ALU;
         ir_write    = 1'b0;
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         iord        = 1'b0;
         reg_write   = 1'b0;
         reg_dst     = 1'b0;
         mem_to_reg  = 1'b0;
         illegal_op  = 1'b0;
         halted      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_alu_ctrl.sv
// Directed bench for mc_alu_ctrl: per-cycle vector table plus hand-written
// reset-mid-access and timeout/HALT sequences (DUT built with MEM_TIMEOUT=4).
module tb_mc_alu_ctrl;

   typedef struct packed {
      logic [1:0] a1;
      logic [1:0] a2;
      logic [2:0] op;
      logic       pw;
      logic [1:0] ps;
      logic       ir;
      logic       mr;
      logic       we;
      logic       io;
      logic       rw;
      logic       rd;
      logic       m2r;
      logic       ill;
      logic       h;
   } out_t;

   typedef struct {
      string      name;
      logic       rst;
      logic [5:0] opc;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero_flag = 1'b0;
   logic       mem_ready = 1'b0;
   out_t       got;

   int errors = 0;
   int checks = 0;
   vec_t tab[$];

   always #5 clk = ~clk;

   mc_alu_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero_flag   (zero_flag),
      .mem_ready   (mem_ready),
      .ALU1control (got.a1),
      .ALU2control (got.a2),
      .ALUop       (got.op),
      .pc_write    (got.pw),
      .pc_src      (got.ps),
      .ir_write    (got.ir),
      .mem_req     (got.mr),
      .mem_we      (got.we),
      .iord        (got.io),
      .reg_write   (got.rw),
      .reg_dst     (got.rd),
      .mem_to_reg  (got.m2r),
      .illegal_op  (got.ill),
      .halted      (got.h)
   );

   function automatic out_t mk(
      logic [1:0] a1, logic [1:0] a2, logic [2:0] op,
      logic pw, logic [1:0] ps, logic ir, logic mr,
      logic we, logic io, logic rw, logic rd,
      logic m2r, logic ill, logic h);
      out_t o;
      o = '{a1, a2, op, pw, ps, ir, mr, we, io, rw, rd, m2r, ill, h};
      return o;
   endfunction

   function automatic void add(string nm, logic r,
      logic [5:0] op, logic [5:0] fn, logic z, logic rdy, out_t e);
      vec_t v;
      v.name = nm;
      v.rst  = r;
      v.opc  = op;
      v.fn   = fn;
      v.z    = z;
      v.rdy  = rdy;
      v.exp  = e;
      tab.push_back(v);
   endfunction

   // Drive one cycle's inputs, check at the falling edge, advance.
   task automatic step(input vec_t v);
      reset     = v.rst;
      opcode    = v.opc;
      funct     = v.fn;
      zero_flag = v.z;
      mem_ready = v.rdy;
      @(negedge clk);
      checks++;
      if (got !== v.exp) begin
         errors++;
         $display("FAIL %s: got %p want %p", v.name, got, v.exp);
      end
      @(posedge clk);
      #1;
   endtask

   out_t Z, FD, FW, DEC, DILL, WBR, ADR, MRD, WBM;
   out_t MWR, XI, WBI, JMP, HLT, LUIX;

   initial begin
      Z    = mk(0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0);
      FD   = mk(0,1,0, 1,0, 1,1,0,0, 0,0,0, 0,0);
      FW   = mk(0,0,0, 0,0, 0,1,0,0, 0,0,0, 0,0);
      DEC  = mk(0,3,0, 0,0, 0,0,0,0, 0,0,0, 0,0);
      DILL = mk(0,3,0, 0,0, 0,0,0,0, 0,0,0, 1,0);
      WBR  = mk(0,0,0, 0,0, 0,0,0,0, 1,1,0, 0,0);
      ADR  = mk(1,2,0, 0,0, 0,0,0,0, 0,0,0, 0,0);
      MRD  = mk(0,0,0, 0,0, 0,1,0,1, 0,0,0, 0,0);
      WBM  = mk(0,0,0, 0,0, 0,0,0,0, 1,0,1, 0,0);
      MWR  = mk(0,0,0, 0,0, 0,1,1,1, 0,0,0, 0,0);
      XI   = mk(1,2,0, 0,0, 0,0,0,0, 0,0,0, 0,0);
      WBI  = mk(0,0,0, 0,0, 0,0,0,0, 1,0,0, 0,0);
      JMP  = mk(0,0,0, 1,2, 0,0,0,0, 0,0,0, 0,0);
      HLT  = mk(0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,1);
      LUIX = mk(3,2,5, 0,0, 0,0,0,0, 0,0,0, 0,0);

      add("reset",     1, 6'h00, 6'h20, 0, 1, Z);
      add("add_fetch", 0, 6'h00, 6'h20, 0, 1, FD);
      add("add_dec",   0, 6'h00, 6'h20, 0, 0, DEC);
      add("add_exec",  0, 6'h00, 6'h20, 0, 0,
          mk(1,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0));
      add("add_wb",    0, 6'h00, 6'h20, 0, 0, WBR);
      add("sub_fetch", 0, 6'h00, 6'h22, 0, 1, FD);
      add("sub_dec",   0, 6'h00, 6'h22, 0, 0, DEC);
      add("sub_exec",  0, 6'h00, 6'h22, 0, 0,
          mk(1,0,1, 0,0, 0,0,0,0, 0,0,0, 0,0));
      add("sub_wb",    0, 6'h00, 6'h22, 0, 0, WBR);
      add("slt_fetch", 0, 6'h00, 6'h2A, 0, 1, FD);
      add("slt_dec",   0, 6'h00, 6'h2A, 0, 0, DEC);
      add("slt_exec",  0, 6'h00, 6'h2A, 0, 0,
          mk(1,0,4, 0,0, 0,0,0,0, 0,0,0, 0,0));
      add("slt_wb",    0, 6'h00, 6'h2A, 0, 0, WBR);
      add("beq1_f",    0, 6'h04, 6'h00, 1, 1, FD);
      add("beq1_d",    0, 6'h04, 6'h00, 1, 0, DEC);
      add("beq1_br",   0, 6'h04, 6'h00, 1, 0,
          mk(1,0,1, 1,1, 0,0,0,0, 0,0,0, 0,0));
      add("beq0_f",    0, 6'h04, 6'h00, 0, 1, FD);
      add("beq0_d",    0, 6'h04, 6'h00, 0, 0, DEC);
      add("beq0_br",   0, 6'h04, 6'h00, 0, 0,
          mk(1,0,1, 0,1, 0,0,0,0, 0,0,0, 0,0));
      add("bne0_f",    0, 6'h05, 6'h00, 0, 1, FD);
      add("bne0_d",    0, 6'h05, 6'h00, 0, 0, DEC);
      add("bne0_br",   0, 6'h05, 6'h00, 0, 0,
          mk(1,0,1, 1,1, 0,0,0,0, 0,0,0, 0,0));
      add("bne1_f",    0, 6'h05, 6'h00, 1, 1, FD);
      add("bne1_d",    0, 6'h05, 6'h00, 1, 0, DEC);
      add("bne1_br",   0, 6'h05, 6'h00, 1, 0,
          mk(1,0,1, 0,1, 0,0,0,0, 0,0,0, 0,0));
      add("lw_f",      0, 6'h23, 6'h00, 0, 1, FD);
      add("lw_d",      0, 6'h23, 6'h00, 0, 0, DEC);
      add("lw_addr",   0, 6'h23, 6'h00, 0, 0, ADR);
      add("lw_wait1",  0, 6'h23, 6'h00, 0, 0, MRD);
      add("lw_wait2",  0, 6'h23, 6'h00, 0, 0, MRD);
      add("lw_wait3",  0, 6'h23, 6'h00, 0, 0, MRD);
      add("lw_rdy",    0, 6'h23, 6'h00, 0, 1, MRD);
      add("lw_wb",     0, 6'h23, 6'h00, 0, 0, WBM);
      add("sw_f",      0, 6'h2B, 6'h00, 0, 1, FD);
      add("sw_d",      0, 6'h2B, 6'h00, 0, 0, DEC);
      add("sw_addr",   0, 6'h2B, 6'h00, 0, 0, ADR);
      add("sw_mem",    0, 6'h2B, 6'h00, 0, 1, MWR);
      add("addi_f",    0, 6'h08, 6'h00, 0, 1, FD);
      add("addi_d",    0, 6'h08, 6'h00, 0, 0, DEC);
      add("addi_x",    0, 6'h08, 6'h00, 0, 0, XI);
      add("addi_wb",   0, 6'h08, 6'h00, 0, 0, WBI);
      // Ready arrives on the last allowed wait cycle: ready wins.
      add("j_wait1",   0, 6'h02, 6'h00, 0, 0, FW);
      add("j_wait2",   0, 6'h02, 6'h00, 0, 0, FW);
      add("j_wait3",   0, 6'h02, 6'h00, 0, 0, FW);
      add("j_rdy_to",  0, 6'h02, 6'h00, 0, 1, FD);
      add("j_d",       0, 6'h02, 6'h00, 0, 0, DEC);
      add("j_jump",    0, 6'h02, 6'h00, 0, 0, JMP);
      add("ill_f",     0, 6'h3F, 6'h00, 0, 1, FD);
      add("ill_d",     0, 6'h3F, 6'h00, 0, 0, DILL);
      add("illfn_f",   0, 6'h00, 6'h3F, 0, 1, FD);
      add("illfn_d",   0, 6'h00, 6'h3F, 0, 0, DILL);
      add("lui_f",     0, 6'h0F, 6'h00, 0, 1, FD);
`ifdef CTRL_LUI_EN
      add("lui_d",     0, 6'h0F, 6'h00, 0, 0, DEC);
      add("lui_x",     0, 6'h0F, 6'h00, 0, 0, LUIX);
      add("lui_wb",    0, 6'h0F, 6'h00, 0, 0, WBI);
`else
      add("lui_d",     0, 6'h0F, 6'h00, 0, 0, DILL);
`endif
      add("after_f",   0, 6'h00, 6'h20, 0, 0, FW);

      @(posedge clk);
      #1;
      foreach (tab[i]) step(tab[i]);
      tab.delete();

      // Reset abandons a lw stuck in MEM_RD.
      add("rst_lw_f",  0, 6'h23, 6'h00, 0, 1, FD);
      add("rst_lw_d",  0, 6'h23, 6'h00, 0, 0, DEC);
      add("rst_lw_a",  0, 6'h23, 6'h00, 0, 0, ADR);
      add("rst_lw_w",  0, 6'h23, 6'h00, 0, 0, MRD);
      add("rst_mid",   1, 6'h23, 6'h00, 0, 1, Z);
      // Fetch never answered: 4 wait cycles then HALT.
      add("to_w1",     0, 6'h23, 6'h00, 0, 0, FW);
      add("to_w2",     0, 6'h23, 6'h00, 0, 0, FW);
      add("to_w3",     0, 6'h23, 6'h00, 0, 0, FW);
      add("to_w4",     0, 6'h23, 6'h00, 0, 0, FW);
      add("halt1",     0, 6'h23, 6'h00, 0, 1, HLT);
      add("halt2",     0, 6'h00, 6'h20, 1, 1, HLT);
      add("halt3",     0, 6'h02, 6'h00, 0, 0, HLT);
      add("halt_rst",  1, 6'h02, 6'h00, 0, 1, Z);
      add("post_f",    0, 6'h02, 6'h00, 0, 1, FD);
      add("post_d",    0, 6'h02, 6'h00, 0, 0, DEC);
      add("post_j",    0, 6'h02, 6'h00, 0, 0, JMP);
      foreach (tab[i]) step(tab[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
